uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_receiver_if.sv | 12 +
 rtl/uart_receiver.sv | 97 +++++++++
 tb/tb_uart_receiver.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-period derivation and FSM state encodings
// for the receive and transmit sides.
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD     = 115200;
    localparam int unsigned DATA_BITS    = 8;

    // Clocks per bit period, integer-truncated (434 at the defaults).
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Serial line in, received byte and completion pulse out.
interface uart_receiver_if;
    import uart_pkg::*;

    logic                 Rx_i;
    logic                 Rx_o_fDone;
    logic [DATA_BITS-1:0] Rx_o_Data;

    modport master (output Rx_i, input Rx_o_fDone, input Rx_o_Data);
    modport slave  (input Rx_i, output Rx_o_fDone, output Rx_o_Data);

endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle done
// pulse per valid frame; framing errors are dropped silently.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = DEF_CLK_FREQ,
    parameter int unsigned BAUD         = DEF_BAUD,
    parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
    input logic           Clk,
    input logic           Rst,
    uart_receiver_if.slave rx
);

    localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    rx_state_t            state;
    logic [1:0]           sync;
    logic [TW-1:0]        timer;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] data_q;
    logic                 done_q;
    logic                 armed;
    logic                 rx_s;

    assign rx_s          = sync[1];
    assign rx.Rx_o_fDone = done_q;
    assign rx.Rx_o_Data  = data_q;

    // armed drops after a framing error or reset so a start is only taken
    // after the line has been seen high again.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync   <= 2'b11;
            state  <= RX_IDLE;
            timer  <= '0;
            idx    <= '0;
            shift  <= '0;
            data_q <= '0;
            done_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync   <= {sync[0], rx.Rx_i};
            done_q <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!armed) begin
                        armed <= rx_s;
                    end else if (!rx_s) begin
                        timer <= '0;
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (timer == HALF) begin
                        timer <= '0;
                        idx   <= '0;
                        state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RX_DATA: begin
                    if (timer == LAST) begin
                        timer      <= '0;
                        shift[idx] <= rx_s;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RX_STOP: begin
                    if (timer == LAST) begin
                        timer <= '0;
                        state <= RX_IDLE;
                        if (rx_s) begin
                            data_q <= shift;
                            done_q <= 1'b1;
                        end else begin
                            armed <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: valid, back-to-back, glitch, framing
// error, mid-frame reset and all-zero/all-one frames at 115200 baud.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int unsigned CPB = 434;
    localparam int unsigned LAT_NOM = 2 + CPB / 2 + 9 * CPB;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    uart_receiver_if rx_bus();

    uart_receiver #(
        .CLK_FREQ(50_000_000),
        .BAUD    (115200)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .rx (rx_bus)
    );

    always #10 Clk = ~Clk;

    int unsigned cyc       = 0;
    int unsigned done_cnt  = 0;
    int unsigned done_cyc  = 0;
    int unsigned dbl_cnt   = 0;
    int unsigned fall_cyc  = 0;
    logic [7:0]  done_data = 8'h00;
    logic        prev_done = 1'b0;
    int          n_checks  = 0;
    int          n_fail    = 0;

    always @(posedge Clk) cyc++;

    // Record every done pulse and flag any pulse longer than one cycle.
    always @(negedge Clk) begin
        if (rx_bus.Rx_o_fDone === 1'b1) begin
            done_cnt++;
            done_cyc  = cyc;
            done_data = rx_bus.Rx_o_Data;
            if (prev_done) dbl_cnt++;
        end
        prev_done = (rx_bus.Rx_o_fDone === 1'b1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_bus.Rx_i = 1'b0;
        fall_cyc    = cyc;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_bus.Rx_i = b[i];
            wait_clks(CPB);
        end
        rx_bus.Rx_i = stop_bit;
        wait_clks(CPB);
        rx_bus.Rx_i = 1'b1;
    endtask

    // Cycles from the first edge seeing the low line to the pulse; nominal +-1.
    function automatic logic lat_ok();
        int unsigned lat;
        lat = done_cyc - fall_cyc - 1;
        return (lat + 1 >= LAT_NOM) && (lat <= LAT_NOM + 1);
    endfunction

    initial begin
        int unsigned n0;
        int unsigned c1;
        logic [7:0]  d1;

        rx_bus.Rx_i = 1'b1;
        Rst = 1'b1;
        wait_clks(4);
        check_eq("rst_data", 32'(rx_bus.Rx_o_Data), 32'h00);
        check_eq("rst_done", 32'(rx_bus.Rx_o_fDone), 32'h0);
        Rst = 1'b0;
        wait_clks(20);

        // Single byte
        n0 = done_cnt;
        send_byte(8'h3C, 1'b1);
        wait_clks(20);
        check_eq("b1_cnt", done_cnt - n0, 32'd1);
        check_eq("b1_data", 32'(rx_bus.Rx_o_Data), 32'h3C);
        check_eq("b1_lat", 32'(lat_ok()), 32'h1);

        // Back-to-back, no idle gap
        n0 = done_cnt;
        send_byte(8'h3C, 1'b1);
        c1 = done_cyc;
        d1 = done_data;
        send_byte(8'hE5, 1'b1);
        wait_clks(20);
        check_eq("b2_cnt", done_cnt - n0, 32'd2);
        check_eq("b2_first", 32'(d1), 32'h3C);
        check_eq("b2_second", 32'(rx_bus.Rx_o_Data), 32'hE5);
        check_eq("b2_spacing", done_cyc - c1, 32'(10 * CPB));

        // Start glitch of 100 clocks
        n0 = done_cnt;
        rx_bus.Rx_i = 1'b0;
        wait_clks(100);
        rx_bus.Rx_i = 1'b1;
        wait_clks(500);
        check_eq("gl_cnt", done_cnt - n0, 32'd0);
        check_eq("gl_data", 32'(rx_bus.Rx_o_Data), 32'hE5);
        send_byte(8'hA5, 1'b1);
        wait_clks(20);
        check_eq("gl_next_cnt", done_cnt - n0, 32'd1);
        check_eq("gl_next_data", 32'(rx_bus.Rx_o_Data), 32'hA5);

        // Framing error: stop bit low
        n0 = done_cnt;
        send_byte(8'h55, 1'b0);
        wait_clks(100);
        check_eq("fe_cnt", done_cnt - n0, 32'd0);
        check_eq("fe_data", 32'(rx_bus.Rx_o_Data), 32'hA5);
        send_byte(8'h0F, 1'b1);
        wait_clks(20);
        check_eq("fe_next_cnt", done_cnt - n0, 32'd1);
        check_eq("fe_next_data", 32'(rx_bus.Rx_o_Data), 32'h0F);

        // Reset during data bit 4 of 0xFF
        n0 = done_cnt;
        rx_bus.Rx_i = 1'b0;
        wait_clks(CPB);
        rx_bus.Rx_i = 1'b1;
        wait_clks(4 * CPB + 200);
        Rst = 1'b1;
        wait_clks(3);
        Rst = 1'b0;
        wait_clks(5 * CPB);
        check_eq("mr_cnt", done_cnt - n0, 32'd0);
        check_eq("mr_data", 32'(rx_bus.Rx_o_Data), 32'h00);
        send_byte(8'h81, 1'b1);
        wait_clks(20);
        check_eq("mr_next_cnt", done_cnt - n0, 32'd1);
        check_eq("mr_next_data", 32'(rx_bus.Rx_o_Data), 32'h81);

        // All-zero and all-one data
        send_byte(8'h00, 1'b1);
        wait_clks(20);
        check_eq("z_data", 32'(rx_bus.Rx_o_Data), 32'h00);
        check_eq("z_lat", 32'(lat_ok()), 32'h1);
        send_byte(8'hFF, 1'b1);
        wait_clks(20);
        check_eq("o_data", 32'(rx_bus.Rx_o_Data), 32'hFF);
        check_eq("o_lat", 32'(lat_ok()), 32'h1);

        check_eq("total_done", done_cnt, 32'd8);
        check_eq("double_pulse", dbl_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
